exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute stage directly downstream of the register bank.
- Consumes the two read operands and current carry, runs the ALU op, and returns the write-back packet: data, destination address, write strobe, and flags with flag-write strobe.
- Single-cycle ops complete in 1 cycle; MUL/DIV are iterative (shift-add / restoring), multi-cycle.

Parameters:
W, 8, operand/result width; fixed at 8 for this processor, parameterised for bench reuse.

Ports:
CLK  input  1  system clock, posedge logic
RST  input  1  synchronous, active-high reset
Start  input  1  accept op; sampled only when Busy=0
Opcode  input  4  operation select, see Behaviour
A  input  W  operand 1 (register bank Out1)
B  input  W  operand 2 (register bank Out2)
CarryIn  input  1  current CF (ADC/SBC)
DestAddr  input  3  destination register
Busy  output  1  op in flight; Start ignored while high
Done  output  1  1-cycle completion pulse
Result  output  W  write-back data (to Datain)
AddrWR  output  3  registered DestAddr
WR  output  1  1-cycle register write strobe
Cout/Oout/Sout/Zout  output  1 each  flags (to Cin/Oin/Sin/Zin)
FlagWR  output  1  1-cycle flag write strobe
IllegalOp  output  1  1-cycle pulse on unsupported opcode

Behaviour:
- Reset: all outputs 0, FSM to IDLE. Reset mid-op discards the op with no WR/FlagWR. Reset wins over Start.
- States: IDLE, MUL, DIV, WB.
- IDLE: on Start, latch A, B, CarryIn, DestAddr and Opcode.
  - Single-cycle op: compute and go to WB.
  - Opcode C: go to MUL. Opcode D or E: go to DIV.
  - Busy rises the cycle after Start for multi-cycle ops only.
- WB: for exactly 1 cycle, Done=1, WR per opcode, FlagWR per opcode. Next state IDLE.
  - Strobes are posedge-registered, so the bank's negedge write lands mid-cycle.
  - Start is accepted in the same cycle Done is high (back-to-back issue).
- Latency (Start edge to Done-high edge): single-cycle ops 1; MUL W+1; DIV W+1.
- Opcodes and flags. C=carry, O=signed overflow, S=Result[W-1], Z=(Result==0).
  - 0 ADD: A+B; C, O per add.
  - 1 ADC: A+B+CarryIn.
  - 2 SUB: A-B; C=borrow.
  - 3 SBC: A-B-CarryIn; C=borrow.
  - 4 AND, 5 OR, 6 XOR, 7 NOT A: C=O=0.
  - 8 SHL: C=A[W-1]. 9 SHR: C=A[0]. A ASR: C=A[0], sign kept. All shifts: O=0.
  - B CMP: flags as SUB, WR=0.
  - C MUL: Result=low W bits of A*B; C=O=(high half!=0).
  - D DIV: quotient. E MOD: remainder. Both: C=0.
  - F MOV: Result=B, WR=1, FlagWR=0.
- FlagWR=1 for all opcodes except F.
- Divide by zero: quotient all-ones, remainder=A, O=1, S and Z computed from Result. DIV still runs the full W iterations.
- Results outside their strobes: Result/flags hold their last value.

Optional Feature:
EXEC_DIV_EN
- Defined: opcodes D/E behave as above; DIV state and divider datapath are present.
- Undefined: no divider logic. D/E complete in 1 cycle with WR=0 and FlagWR=0; Done=1 and IllegalOp=1 in that WB cycle.

Test Plan:
- Reset, then ADD A=0x7F, B=0x01 -> 1 cycle later Result=0x80, WR=1, FlagWR=1, C=0, O=1, S=1, Z=0.
- SBC A=0x00, B=0x00, CarryIn=1 -> Result=0xFF, C=1, O=0, S=1. Then CMP A=5, B=5 -> Z=1, WR=0, FlagWR=1.
- MUL A=0x10, B=0x20 -> Busy for 8 cycles, Done on cycle 9, Result=0x00, C=O=1, Z=1. Start pulsed mid-op is ignored.
- DIV A=200, B=7 -> Result=28. MOD A=200, B=7 -> Result=4. DIV A=9, B=0 -> Result=0xFF, O=1. Without EXEC_DIV_EN: IllegalOp=1, WR=0.
- Back-to-back: ADD accepted in the Done cycle of a MUL -> ADD WB on the next cycle with correct AddrWR.
- Assert RST in cycle 4 of a MUL -> no WR/Done; all outputs 0 next cycle; a fresh op then completes normally.

Source files
------------

// File: rtl/exec_unit_if.sv
// exec_unit_if: issue / write-back bundle between the control path and exec_unit.
//   master : issuer side, drives Start/Opcode/A/B/CarryIn/DestAddr and observes the results.
//   slave  : exec_unit side, returns Busy/Done/Result/AddrWR/WR, the four flags,
//            FlagWR and IllegalOp.
// Parameter W : operand/result width.
interface exec_unit_if #(
   parameter int unsigned W = 8
) ();
   logic         Start;
   logic [3:0]   Opcode;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         CarryIn;
   logic [2:0]   DestAddr;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Result;
   logic [2:0]   AddrWR;
   logic         WR;
   logic         Cout;
   logic         Oout;
   logic         Sout;
   logic         Zout;
   logic         FlagWR;
   logic         IllegalOp;

   modport master (
      output Start, Opcode, A, B, CarryIn, DestAddr,
      input  Busy, Done, Result, AddrWR, WR, Cout, Oout, Sout, Zout, FlagWR, IllegalOp
   );

   modport slave (
      input  Start, Opcode, A, B, CarryIn, DestAddr,
      output Busy, Done, Result, AddrWR, WR, Cout, Oout, Sout, Zout, FlagWR, IllegalOp
   );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage behind the register bank.
//   Accepts an op on bus.Start while Busy is low and latches its operands. After the op
//   finishes it returns a one-cycle write-back packet: Result, AddrWR, WR, the flags
//   Cout/Oout/Sout/Zout, FlagWR, IllegalOp and a Done pulse. Single-cycle ops finish one
//   edge after acceptance; MUL (shift-add) and DIV/MOD (restoring) take W+1 edges.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous, active-high reset
//   bus : exec_unit_if slave modport (issue inputs, write-back outputs)
// Build option:
//   EXEC_DIV_EN : when defined, opcodes D/E use the iterative divider. When it is not
//                 defined, D/E finish in one cycle with IllegalOp set and no write strobes.
// W must be at least 2.
module exec_unit #(
   parameter int unsigned W = 8
) (
   input logic        CLK,
   input logic        RST,
   exec_unit_if.slave bus
);

   localparam int unsigned      CntW    = $clog2(W + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

   localparam logic [3:0] OpAdd = 4'h0;
   localparam logic [3:0] OpAdc = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
   localparam logic [3:0] OpSbc = 4'h3;
   localparam logic [3:0] OpAnd = 4'h4;
   localparam logic [3:0] OpOr  = 4'h5;
   localparam logic [3:0] OpXor = 4'h6;
   localparam logic [3:0] OpNot = 4'h7;
   localparam logic [3:0] OpShl = 4'h8;
   localparam logic [3:0] OpShr = 4'h9;
   localparam logic [3:0] OpAsr = 4'hA;
   localparam logic [3:0] OpCmp = 4'hB;
   localparam logic [3:0] OpMul = 4'hC;
   localparam logic [3:0] OpDiv = 4'hD;
   localparam logic [3:0] OpMod = 4'hE;
   localparam logic [3:0] OpMov = 4'hF;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StWb} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic           cin_q, cin_d;
   logic [3:0]     op_q, op_d;
   logic [2:0]     dst_q, dst_d;
   // MUL: {partial high, multiplier shifting out}. DIV: {remainder, dividend/quotient}.
   logic [2*W-1:0] prod_q, prod_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic           busy_q, busy_d, done_q, done_d, wr_q, wr_d;
   logic           flag_wr_q, flag_wr_d, illegal_q, illegal_d;
   logic [W-1:0]   result_q, result_d;
   logic [2:0]     addr_wr_q, addr_wr_d;
   logic           c_q, c_d, o_q, o_d, s_q, s_d, z_q, z_d;

   logic [W:0]     add_ext, sub_ext, mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W-1:0]   alu_res;
   logic           alu_c, alu_o, alu_wr, alu_fwr, alu_ill;
   logic           accept;

   // One shift-add step: add A when the multiplier LSB is set, then shift right.
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : {(W + 1){1'b0}});
      mul_next = {mul_sum, prod_q[W-1:1]};
   end

`ifdef EXEC_DIV_EN
   logic [W:0]     div_part, div_trial;
   logic [2*W-1:0] div_next;

   // One restoring step. remainder < divisor holds, so bit W of the trial is the sign.
   // A zero divisor always "fits". This produces an all-ones quotient and a remainder of A.
   always_comb begin
      div_part  = prod_q[2*W-1:W-1];
      div_trial = div_part - {1'b0, b_q};
      if (!div_trial[W]) begin
         div_next = {div_trial[W-1:0], prod_q[W-2:0], 1'b1};
      end else begin
         div_next = {div_part[W-1:0], prod_q[W-2:0], 1'b0};
      end
   end
`endif

   // Write-back value, flags and strobes for the latched op.
   always_comb begin
      add_ext = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, (op_q == OpAdc) & cin_q};
      sub_ext = {1'b0, a_q} - {1'b0, b_q} - {{W{1'b0}}, (op_q == OpSbc) & cin_q};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_o   = 1'b0;
      alu_wr  = 1'b1;
      alu_fwr = 1'b1;
      alu_ill = 1'b0;
      case (op_q)
         OpAdd, OpAdc: begin
            alu_res = add_ext[W-1:0];
            alu_c   = add_ext[W];
            alu_o   = (a_q[W-1] == b_q[W-1]) && (add_ext[W-1] != a_q[W-1]);
         end
         OpSub, OpSbc, OpCmp: begin
            alu_res = sub_ext[W-1:0];
            alu_c   = sub_ext[W];  // borrow
            alu_o   = (a_q[W-1] != b_q[W-1]) && (sub_ext[W-1] != a_q[W-1]);
            alu_wr  = (op_q != OpCmp);
         end
         OpAnd: alu_res = a_q & b_q;
         OpOr:  alu_res = a_q | b_q;
         OpXor: alu_res = a_q ^ b_q;
         OpNot: alu_res = ~a_q;
         OpShl: begin
            alu_res = {a_q[W-2:0], 1'b0};
            alu_c   = a_q[W-1];
         end
         OpShr: begin
            alu_res = {1'b0, a_q[W-1:1]};
            alu_c   = a_q[0];
         end
         OpAsr: begin
            alu_res = {a_q[W-1], a_q[W-1:1]};
            alu_c   = a_q[0];
         end
         OpMul: begin
            alu_res = prod_q[W-1:0];
            alu_c   = |prod_q[2*W-1:W];
            alu_o   = |prod_q[2*W-1:W];
         end
`ifdef EXEC_DIV_EN
         OpDiv: begin
            alu_res = prod_q[W-1:0];
            alu_o   = (b_q == '0);
         end
         OpMod: begin
            alu_res = prod_q[2*W-1:W];
            alu_o   = (b_q == '0);
         end
`else
         OpDiv, OpMod: begin
            alu_wr  = 1'b0;
            alu_fwr = 1'b0;
            alu_ill = 1'b1;
         end
`endif
         OpMov: begin
            alu_res = b_q;
            alu_fwr = 1'b0;
         end
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cin_d     = cin_q;
      op_d      = op_q;
      dst_d     = dst_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      wr_d      = 1'b0;
      flag_wr_d = 1'b0;
      illegal_d = 1'b0;
      result_d  = result_q;
      addr_wr_d = addr_wr_q;
      c_d       = c_q;
      o_d       = o_q;
      s_d       = s_q;
      z_d       = z_q;
      accept    = 1'b0;

      case (state_q)
         StIdle: accept = bus.Start;
         StMul: begin
            prod_d = mul_next;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntLast) state_d = StWb;
         end
`ifdef EXEC_DIV_EN
         StDiv: begin
            prod_d = div_next;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntLast) state_d = StWb;
         end
`endif
         StWb: begin
            done_d    = 1'b1;
            wr_d      = alu_wr;
            flag_wr_d = alu_fwr;
            illegal_d = alu_ill;
            addr_wr_d = dst_q;
            if (alu_wr) result_d = alu_res;
            if (alu_fwr) begin
               c_d = alu_c;
               o_d = alu_o;
               s_d = alu_res[W-1];
               z_d = (alu_res == '0);
            end
            state_d = StIdle;
            // Busy is low here, so a new op can issue while this one writes back.
            accept  = bus.Start;
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         a_d     = bus.A;
         b_d     = bus.B;
         cin_d   = bus.CarryIn;
         op_d    = bus.Opcode;
         dst_d   = bus.DestAddr;
         cnt_d   = '0;
         state_d = StWb;
         if (bus.Opcode == OpMul) begin
            state_d = StMul;
            prod_d  = {{W{1'b0}}, bus.B};
         end
`ifdef EXEC_DIV_EN
         else if ((bus.Opcode == OpDiv) || (bus.Opcode == OpMod)) begin
            state_d = StDiv;
            prod_d  = {{W{1'b0}}, bus.A};
         end
`endif
      end

      busy_d = (state_d == StMul) || (state_d == StDiv);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         op_q      <= '0;
         dst_q     <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= 1'b0;
         flag_wr_q <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= '0;
         addr_wr_q <= '0;
         c_q       <= 1'b0;
         o_q       <= 1'b0;
         s_q       <= 1'b0;
         z_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cin_q     <= cin_d;
         op_q      <= op_d;
         dst_q     <= dst_d;
         prod_q    <= prod_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_q      <= wr_d;
         flag_wr_q <= flag_wr_d;
         illegal_q <= illegal_d;
         result_q  <= result_d;
         addr_wr_q <= addr_wr_d;
         c_q       <= c_d;
         o_q       <= o_d;
         s_q       <= s_d;
         z_q       <= z_d;
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.WR        = wr_q;
   assign bus.FlagWR    = flag_wr_q;
   assign bus.IllegalOp = illegal_q;
   assign bus.Result    = result_q;
   assign bus.AddrWR    = addr_wr_q;
   assign bus.Cout      = c_q;
   assign bus.Oout      = o_q;
   assign bus.Sout      = s_q;
   assign bus.Zout      = z_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed plus random stimulus for exec_unit, checked every cycle
// against an arithmetic reference model held in queues.
`timescale 1ns/1ps
module tb_exec_unit;
   localparam int W    = 8;
   localparam int Mask = (1 << W) - 1;
   localparam int SMax = (1 << (W - 1)) - 1;
   localparam int SMin = -(1 << (W - 1));

   logic CLK = 1'b0;
   logic RST = 1'b1;

   exec_unit_if #(.W(W)) bus ();
   exec_unit #(.W(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   typedef struct {
      int done_at;
      int res;
      bit c, o, s, z, wr, fwr, ill;
      int dst;
   } rec_t;

   rec_t pend[$];
   int   cyc = 0;
   int   busy_lo = 1, busy_hi = 0;
   int   n_chk = 0, n_fail = 0;
   bit   e_done, e_wr, e_fwr, e_ill, e_busy, e_c, e_o, e_s, e_z, addr_chk;
   int   e_res, e_addr;

   function automatic int to_signed(input int v);
      return (v > SMax) ? v - (1 << W) : v;
   endfunction

   function automatic bit is_multi(input int op);
`ifdef EXEC_DIV_EN
      return (op == 12) || (op == 13) || (op == 14);
`else
      return (op == 12);
`endif
   endfunction

   // Reference result of one op, computed from the opcode table with plain integers.
   function automatic rec_t ref_op(input int op, input int a, input int b, input int cin);
      rec_t r;
      int   full, sf, p, ci;
      r.done_at = 0; r.res = 0; r.c = 0; r.o = 0; r.s = 0; r.z = 0;
      r.wr = 1; r.fwr = 1; r.ill = 0; r.dst = 0;
      ci = (op == 1 || op == 3) ? cin : 0;
      case (op)
         0, 1: begin
            full  = a + b + ci;
            sf    = to_signed(a) + to_signed(b) + ci;
            r.res = full & Mask;
            r.c   = full > Mask;
            r.o   = (sf > SMax) || (sf < SMin);
         end
         2, 3, 11: begin
            full  = a - b - ci;
            sf    = to_signed(a) - to_signed(b) - ci;
            r.res = full & Mask;
            r.c   = full < 0;
            r.o   = (sf > SMax) || (sf < SMin);
            r.wr  = (op != 11);
         end
         4: r.res = a & b;
         5: r.res = a | b;
         6: r.res = a ^ b;
         7: r.res = (~a) & Mask;
         8: begin r.res = (a << 1) & Mask; r.c = ((a >> (W - 1)) & 1) != 0; end
         9: begin r.res = a >> 1; r.c = (a & 1) != 0; end
         10: begin r.res = (a >> 1) | (a & (1 << (W - 1))); r.c = (a & 1) != 0; end
         12: begin
            p     = a * b;
            r.res = p & Mask;
            r.c   = (p >> W) != 0;
            r.o   = r.c;
         end
         13, 14: begin
`ifdef EXEC_DIV_EN
            if (b == 0) begin
               r.res = (op == 13) ? Mask : a;
               r.o   = 1;
            end else begin
               r.res = (op == 13) ? a / b : a % b;
            end
`else
            r.wr = 0; r.fwr = 0; r.ill = 1;
`endif
         end
         default: begin r.res = b; r.fwr = 0; end
      endcase
      r.s = ((r.res >> (W - 1)) & 1) != 0;
      r.z = (r.res == 0);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Advance the model across one rising edge using the inputs the bench drove.
   task automatic model_edge();
      rec_t r;
      bit   was_busy;
      cyc++;
      e_done = 0; e_wr = 0; e_fwr = 0; e_ill = 0; addr_chk = 0;
      if (RST) begin
         pend.delete();
         busy_lo = 1; busy_hi = 0;
         e_res = 0; e_addr = 0; e_c = 0; e_o = 0; e_s = 0; e_z = 0;
         addr_chk = 1;
      end else begin
         was_busy = (cyc - 1 >= busy_lo) && (cyc - 1 <= busy_hi);
         if (pend.size() > 0 && pend[0].done_at == cyc) begin
            r = pend.pop_front();
            e_done = 1; e_wr = r.wr; e_fwr = r.fwr; e_ill = r.ill;
            e_addr = r.dst; addr_chk = 1;
            if (r.wr) e_res = r.res;
            if (r.fwr) begin e_c = r.c; e_o = r.o; e_s = r.s; e_z = r.z; end
         end
         if (bus.Start && !was_busy) begin
            r = ref_op(int'(bus.Opcode), int'(bus.A), int'(bus.B), int'(bus.CarryIn));
            r.dst = int'(bus.DestAddr);
            if (is_multi(int'(bus.Opcode))) begin
               r.done_at = cyc + W + 1;
               busy_lo   = cyc;
               busy_hi   = cyc + W - 1;
            end else begin
               r.done_at = cyc + 1;
            end
            pend.push_back(r);
         end
      end
      e_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
   endtask

   task automatic compare();
      chk("done", bus.Done, e_done);
      chk("wr", bus.WR, e_wr);
      chk("flag_wr", bus.FlagWR, e_fwr);
      chk("illegal", bus.IllegalOp, e_ill);
      chk("busy", bus.Busy, e_busy);
      chk("result", bus.Result, e_res);
      chk("cout", bus.Cout, e_c);
      chk("oout", bus.Oout, e_o);
      chk("sout", bus.Sout, e_s);
      chk("zout", bus.Zout, e_z);
      if (addr_chk) chk("addr_wr", bus.AddrWR, e_addr);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      compare();
   endtask

   task automatic drive(input int op, input int a, input int b, input int cin, input int dst);
      bus.Start    = 1'b1;
      bus.Opcode   = 4'(op);
      bus.A        = W'(a);
      bus.B        = W'(b);
      bus.CarryIn  = cin[0];
      bus.DestAddr = 3'(dst);
   endtask

   task automatic idle();
      bus.Start = 1'b0;
   endtask

   task automatic issue_wait(input int op, input int a, input int b, input int cin,
                             input int dst, output int n);
      drive(op, a, b, cin, dst);
      tick();
      idle();
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.Done && n < 40);
      chk("done_seen", bus.Done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t p;
      int   n, busy_cnt, dones;

      bus.Start = 1'b0; bus.Opcode = '0; bus.A = '0; bus.B = '0;
      bus.CarryIn = 1'b0; bus.DestAddr = '0;

      // Pin the reference model against hand-worked values.
      p = ref_op(0, 'h7F, 'h01, 0);
      chk("pin_add_res", p.res, 'h80);
      chk("pin_add_o", p.o, 1);
      p = ref_op(3, 0, 0, 1);
      chk("pin_sbc_res", p.res, 'hFF);
      chk("pin_sbc_c", p.c, 1);
      p = ref_op(12, 'h10, 'h20, 0);
      chk("pin_mul_res", p.res, 0);
      chk("pin_mul_c", p.c, 1);
      p = ref_op(10, 'h81, 0, 0);
      chk("pin_asr_res", p.res, 'hC0);
`ifdef EXEC_DIV_EN
      p = ref_op(13, 200, 7, 0);
      chk("pin_div_res", p.res, 28);
      p = ref_op(14, 200, 7, 0);
      chk("pin_mod_res", p.res, 4);
      p = ref_op(13, 9, 0, 0);
      chk("pin_div0_res", p.res, 'hFF);
`else
      p = ref_op(13, 200, 7, 0);
      chk("pin_div_ill", p.ill, 1);
`endif

      // Reset.
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      tick();

      // ADD 0x7F + 0x01.
      issue_wait(0, 'h7F, 'h01, 0, 3, n);
      chk("add_lat", n, 1);
      chk("add_res", bus.Result, 'h80);
      chk("add_wr", bus.WR, 1);
      chk("add_fwr", bus.FlagWR, 1);
      chk("add_flags", {bus.Cout, bus.Oout, bus.Sout, bus.Zout}, 4'b0110);
      chk("add_addr", bus.AddrWR, 3);

      // SBC 0 - 0 - 1, then CMP 5, 5.
      issue_wait(3, 0, 0, 1, 2, n);
      chk("sbc_res", bus.Result, 'hFF);
      chk("sbc_flags", {bus.Cout, bus.Oout, bus.Sout}, 3'b101);
      issue_wait(11, 5, 5, 0, 1, n);
      chk("cmp_z", bus.Zout, 1);
      chk("cmp_wr", bus.WR, 0);
      chk("cmp_fwr", bus.FlagWR, 1);

      // MUL 0x10 * 0x20 with a stray Start while busy.
      drive(12, 'h10, 'h20, 0, 4);
      tick();
      idle();
      busy_cnt = int'(bus.Busy);
      n = 0;
      do begin
         if (n == 3) drive(0, 1, 1, 0, 7);
         else idle();
         tick();
         n++;
         busy_cnt += int'(bus.Busy);
      end while (!bus.Done && n < 40);
      chk("mul_lat", n, W + 1);
      chk("mul_busy_cycles", busy_cnt, W);
      chk("mul_res", bus.Result, 0);
      chk("mul_flags", {bus.Cout, bus.Oout, bus.Zout}, 3'b111);
      chk("mul_addr", bus.AddrWR, 4);

      // Back-to-back ADD issued in the MUL Done cycle.
      drive(0, 'h21, 'h12, 0, 5);
      tick();
      idle();
      tick();
      chk("b2b_done", bus.Done, 1);
      chk("b2b_res", bus.Result, 'h33);
      chk("b2b_addr", bus.AddrWR, 5);

`ifdef EXEC_DIV_EN
      issue_wait(13, 200, 7, 0, 6, n);
      chk("div_lat", n, W + 1);
      chk("div_res", bus.Result, 28);
      issue_wait(14, 200, 7, 0, 6, n);
      chk("mod_res", bus.Result, 4);
      issue_wait(13, 9, 0, 0, 6, n);
      chk("div0_lat", n, W + 1);
      chk("div0_res", bus.Result, 'hFF);
      chk("div0_o", bus.Oout, 1);
`else
      issue_wait(13, 200, 7, 0, 6, n);
      chk("div_lat", n, 1);
      chk("div_ill", bus.IllegalOp, 1);
      chk("div_wr", bus.WR, 0);
      chk("div_fwr", bus.FlagWR, 0);
`endif

      // Reset in the middle of a MUL, then a fresh op.
      drive(12, 3, 5, 0, 2);
      tick();
      idle();
      tick();
      tick();
      tick();
      RST = 1'b1;
      tick();
      chk("rst_done", bus.Done, 0);
      chk("rst_result", bus.Result, 0);
      RST = 1'b0;
      dones = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         dones += int'(bus.Done) + int'(bus.WR);
      end
      chk("rst_no_wb", dones, 0);
      issue_wait(0, 2, 3, 0, 1, n);
      chk("post_rst_res", bus.Result, 5);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         RST          = ($urandom_range(0, 199) == 0);
         bus.Start    = $urandom_range(0, 1) != 0;
         bus.Opcode   = 4'($urandom_range(0, 15));
         bus.A        = W'($urandom);
         bus.B        = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
         bus.CarryIn  = $urandom_range(0, 1) != 0;
         bus.DestAddr = 3'($urandom);
         tick();
      end
      RST = 1'b0;
      idle();
      for (int i = 0; i < W + 4; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
